// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - partial-sum accumulator with ReLU and 4-entry output FIFO
module psum_accumulator #(
  parameter int W = 16,
  parameter int A = 7
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic [W-1:0] sumIn,
  input  logic [A-1:0] sumAddr,
  input  logic         sumValid,
  output logic         sumReady,
  input  logic         firstPass,
  input  logic         lastPass,
  input  logic         doRelu,
  output logic [W-1:0] outData,
  output logic [A-1:0] outAddr,
  output logic         outValid,
  input  logic         outReady
);

  localparam int BUF_DEPTH  = 1 << A;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

  // Accumulation buffer: not reset, the first pass of each address overwrites it.
  logic [W-1:0] acc_buf_q [BUF_DEPTH];

  // Output FIFO storage and bookkeeping.
  logic [W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [A-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   count_q, count_d;
  fifo_state_e  state_q, state_d;

  logic         accept;
  logic         push;
  logic         pop;
  logic [W-1:0] buf_rd;
  logic [W-1:0] sum;
  logic [W-1:0] result;

  // Ready depends on stored occupancy only, never on this cycle's pop.
  assign sumReady = (count_q != 3'd4);
  assign outValid = (state_q != ST_EMPTY);
  assign outData  = fifo_data_q[rd_ptr_q];
  assign outAddr  = fifo_addr_q[rd_ptr_q];

  assign accept = sumValid && sumReady;
  assign push   = accept && lastPass;
  assign pop    = outValid && outReady;

  // Read-modify-write datapath: asynchronous buffer read, modulo-2^W add, ReLU on the FIFO copy.
  always_comb begin
    buf_rd = acc_buf_q[sumAddr];
    sum    = firstPass ? sumIn : (buf_rd + sumIn);
    result = (doRelu && sum[W-1]) ? '0 : sum;
  end

  // Buffer write on every accept, including the last pass.
  always_ff @(posedge CLK) begin
    if (accept) begin
      acc_buf_q[sumAddr] <= sum;
    end
  end

  // FIFO storage write at the write pointer; cleared on reset so the head reads 0 when idle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= result;
      fifo_addr_q[wr_ptr_q] <= sumAddr;
    end
  end

  // Pointer and occupancy next-state; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO occupancy state transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push && !pop) begin
          state_d = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (push && !pop && (count_q == 3'd3)) begin
          state_d = ST_FULL;
        end else if (pop && !push && (count_q == 3'd1)) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_PARTIAL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // FIFO control registers; reset discards every queued result immediately.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      state_q  <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed self-checking bench for psum_accumulator
module tb_psum_accumulator;

  logic        CLK;
  logic        RESETn;
  logic [15:0] sumIn;
  logic [6:0]  sumAddr;
  logic        sumValid;
  logic        sumReady;
  logic        firstPass;
  logic        lastPass;
  logic        doRelu;
  logic [15:0] outData;
  logic [6:0]  outAddr;
  logic        outValid;
  logic        outReady;

  int checks = 0;
  int errors = 0;

  logic [22:0] mon_q[$];

  psum_accumulator #(.W(16), .A(7)) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .sumIn     (sumIn),
    .sumAddr   (sumAddr),
    .sumValid  (sumValid),
    .sumReady  (sumReady),
    .firstPass (firstPass),
    .lastPass  (lastPass),
    .doRelu    (doRelu),
    .outData   (outData),
    .outAddr   (outAddr),
    .outValid  (outValid),
    .outReady  (outReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Records every pop; sampled at the falling edge ahead of the rising edge that pops.
  always @(negedge CLK) begin
    if (RESETn && outValid && outReady) begin
      mon_q.push_back({outAddr, outData});
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] a, input logic [15:0] d,
                      input logic f, input logic l, input logic r);
    int n;
    sumAddr = a; sumIn = d; firstPass = f; lastPass = l; doRelu = r;
    sumValid = 1'b1;
    n = 0;
    while (!sumReady && n < 20) begin
      cycle(1);
      n++;
    end
    checks++;
    if (sumReady !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout addr=%0d sumReady=%b required 1", a, sumReady);
    end
    cycle(1);
    sumValid = 1'b0;
  endtask

  task automatic test_reset;
    RESETn = 1'b0;
    sumValid = 1'b0; sumIn = '0; sumAddr = '0;
    firstPass = 1'b0; lastPass = 1'b0; doRelu = 1'b0; outReady = 1'b0;
    cycle(2);
    RESETn = 1'b1;
    cycle(2);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b want 0", outValid); end
    checks++;
    if (sumReady !== 1'b1) begin errors++; $display("FAIL reset_sumReady got %b want 1", sumReady); end
    checks++;
    if (outData !== 16'h0000) begin errors++; $display("FAIL reset_outData got %h want 0000", outData); end
    checks++;
    if (outAddr !== 7'd0) begin errors++; $display("FAIL reset_outAddr got %0d want 0", outAddr); end
  endtask

  task automatic test_three_pass;
    outReady = 1'b1;
    send(7'd5, 16'd100, 1'b1, 1'b0, 1'b0);
    send(7'd5, 16'd200, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL three_pass_early got outValid=%b want 0", outValid); end
    send(7'd5, 16'd50, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b1) begin errors++; $display("FAIL three_pass_valid got %b want 1", outValid); end
    checks++;
    if (outData !== 16'd350) begin errors++; $display("FAIL three_pass_data got %0d want 350", outData); end
    checks++;
    if (outAddr !== 7'd5) begin errors++; $display("FAIL three_pass_addr got %0d want 5", outAddr); end
    cycle(1);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL three_pass_drain got outValid=%b want 0", outValid); end
  endtask

  task automatic test_wrap_relu;
    outReady = 1'b1;
    send(7'd0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    send(7'd0, 16'h0002, 1'b0, 1'b1, 1'b1);
    checks++;
    if (outData !== 16'h0000 || outValid !== 1'b1) begin
      errors++; $display("FAIL wrap_relu got %h valid=%b want 0000 valid=1", outData, outValid);
    end
    send(7'd0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    send(7'd0, 16'h0002, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outData !== 16'h8001 || outValid !== 1'b1) begin
      errors++; $display("FAIL wrap_norelu got %h valid=%b want 8001 valid=1", outData, outValid);
    end
    send(7'd3, 16'hFFFD, 1'b1, 1'b1, 1'b1);
    checks++;
    if (outData !== 16'h0000 || outAddr !== 7'd3) begin
      errors++; $display("FAIL single_relu got %h addr=%0d want 0000 addr=3", outData, outAddr);
    end
    send(7'd3, 16'hFFFD, 1'b1, 1'b1, 1'b0);
    checks++;
    if (outData !== 16'hFFFD || outAddr !== 7'd3) begin
      errors++; $display("FAIL single_norelu got %h addr=%0d want fffd addr=3", outData, outAddr);
    end
    cycle(1);
  endtask

  task automatic test_back_to_back;
    outReady = 1'b1;
    send(7'd127, 16'd1, 1'b1, 1'b0, 1'b0);
    send(7'd127, 16'd2, 1'b0, 1'b0, 1'b0);
    send(7'd127, 16'd3, 1'b0, 1'b0, 1'b0);
    send(7'd127, 16'd4, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outData !== 16'd10 || outAddr !== 7'd127) begin
      errors++; $display("FAIL b2b_same got %0d addr=%0d want 10 addr=127", outData, outAddr);
    end
    send(7'd1, 16'd10, 1'b1, 1'b0, 1'b0);
    send(7'd2, 16'd20, 1'b1, 1'b0, 1'b0);
    send(7'd1, 16'd5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outData !== 16'd15 || outAddr !== 7'd1) begin
      errors++; $display("FAIL interleave_a1 got %0d addr=%0d want 15 addr=1", outData, outAddr);
    end
    send(7'd2, 16'd7, 1'b0, 1'b1, 1'b0);
    checks++;
    if (outData !== 16'd27 || outAddr !== 7'd2) begin
      errors++; $display("FAIL interleave_a2 got %0d addr=%0d want 27 addr=2", outData, outAddr);
    end
    cycle(1);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL interleave_drain got outValid=%b want 0", outValid); end
  endtask

  task automatic test_full;
    logic [6:0]  exp_a [5];
    logic [15:0] exp_d [5];
    exp_a = '{7'd10, 7'd11, 7'd12, 7'd13, 7'd20};
    exp_d = '{16'd1000, 16'd1001, 16'd1002, 16'd1003, 16'd55};
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) send(exp_a[i], exp_d[i], 1'b1, 1'b1, 1'b0);
    checks++;
    if (sumReady !== 1'b0) begin errors++; $display("FAIL full_sumReady got %b want 0", sumReady); end
    checks++;
    if (outAddr !== 7'd10 || outData !== 16'd1000) begin
      errors++; $display("FAIL full_head got addr=%0d data=%0d want addr=10 data=1000", outAddr, outData);
    end
    sumAddr = 7'd20; sumIn = 16'd55; firstPass = 1'b1; lastPass = 1'b1; doRelu = 1'b0;
    sumValid = 1'b1;
    cycle(3);
    checks++;
    if (sumReady !== 1'b0 || outAddr !== 7'd10) begin
      errors++; $display("FAIL full_hold got sumReady=%b head=%0d want 0 head=10", sumReady, outAddr);
    end
    mon_q.delete();
    outReady = 1'b1;
    cycle(1);
    checks++;
    if (sumReady !== 1'b1 || outAddr !== 7'd11) begin
      errors++; $display("FAIL full_first_pop got sumReady=%b head=%0d want 1 head=11", sumReady, outAddr);
    end
    cycle(1);
    sumValid = 1'b0;
    cycle(6);
    checks++;
    if (mon_q.size() !== 5) begin
      errors++; $display("FAIL full_count got %0d outputs want 5", mon_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (mon_q[i] !== {exp_a[i], exp_d[i]}) begin
          errors++;
          $display("FAIL full_order[%0d] got addr=%0d data=%0d want addr=%0d data=%0d",
                   i, mon_q[i][22:16], mon_q[i][15:0], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_simul_push_pop;
    outReady = 1'b0;
    send(7'd30, 16'd300, 1'b1, 1'b1, 1'b0);
    send(7'd31, 16'd310, 1'b1, 1'b1, 1'b0);
    mon_q.delete();
    outReady = 1'b1;
    send(7'd32, 16'd320, 1'b1, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b1 || outAddr !== 7'd31) begin
      errors++; $display("FAIL simul_head got valid=%b head=%0d want 1 head=31", outValid, outAddr);
    end
    cycle(1);
    checks++;
    if (outValid !== 1'b1 || outAddr !== 7'd32 || outData !== 16'd320) begin
      errors++; $display("FAIL simul_second got valid=%b addr=%0d data=%0d want 1 32 320", outValid, outAddr, outData);
    end
    cycle(1);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL simul_count got outValid=%b want 0", outValid); end
    checks++;
    if (mon_q.size() !== 3 || mon_q[0][22:16] !== 7'd30 || mon_q[1][22:16] !== 7'd31 || mon_q[2][22:16] !== 7'd32) begin
      errors++; $display("FAIL simul_order got %0d outputs, want 30,31,32 in order", mon_q.size());
    end
  endtask

  task automatic test_pointer_wrap;
    logic [15:0] d;
    mon_q.delete();
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 16'(i * 3 + 1);
      send(7'(40 + i), d, 1'b1, 1'b1, 1'b0);
    end
    cycle(3);
    checks++;
    if (mon_q.size() !== 10) begin
      errors++; $display("FAIL wrap_count got %0d outputs want 10", mon_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        d = 16'(i * 3 + 1);
        checks++;
        if (mon_q[i] !== {7'(40 + i), d}) begin
          errors++;
          $display("FAIL wrap_order[%0d] got addr=%0d data=%0d want addr=%0d data=%0d",
                   i, mon_q[i][22:16], mon_q[i][15:0], 40 + i, d);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    outReady = 1'b0;
    send(7'd60, 16'd600, 1'b1, 1'b1, 1'b0);
    send(7'd61, 16'd610, 1'b1, 1'b1, 1'b0);
    send(7'd62, 16'd620, 1'b1, 1'b1, 1'b0);
    checks++;
    if (outValid !== 1'b1 || outAddr !== 7'd60) begin
      errors++; $display("FAIL mid_queued got valid=%b head=%0d want 1 head=60", outValid, outAddr);
    end
    #1 RESETn = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL mid_async_outValid got %b want 0", outValid); end
    checks++;
    if (sumReady !== 1'b1) begin errors++; $display("FAIL mid_async_sumReady got %b want 1", sumReady); end
    checks++;
    if (outData !== 16'h0000 || outAddr !== 7'd0) begin
      errors++; $display("FAIL mid_async_head got data=%h addr=%0d want 0000 0", outData, outAddr);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    cycle(2);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("FAIL mid_after_release got outValid=%b want 0", outValid); end
  endtask

  initial begin
    test_reset();
    test_three_pass();
    test_wrap_relu();
    test_back_to_back();
    test_full();
    test_simul_push_pop();
    test_pointer_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
